// File: rtl/mac_pkg.sv
// Shared constants, types and the round-robin pick helper for the MAC arbiter.
package mac_pkg;
   localparam int MAC_DEFAULT_WIDTH   = 16;
   localparam int MAC_DEFAULT_LATENCY = 3;
   localparam int MAC_DEFAULT_NUM_REQ = 4;
   localparam int MAC_MAX_REQ         = 32;

   typedef logic [$clog2(MAC_DEFAULT_NUM_REQ)-1:0] mac_id_t;

   // Returns the first valid index after 'last' (wrapping), or -1 when none is valid.
   function automatic int rr_pick(input logic [MAC_MAX_REQ-1:0] valid,
                                  input int last,
                                  input int num_req);
      int         pick;
      logic [4:0] idx;
      pick = -1;
      // Walk from far to near so the nearest valid index is the one left standing.
      for (int k = MAC_MAX_REQ; k >= 1; k--) begin
         if (k <= num_req) begin
            idx = 5'((last + k) % num_req);
            if (valid[idx]) pick = int'(idx);
         end
      end
      return pick;
   endfunction
endpackage

// File: rtl/mac_arbiter_if.sv
// Request/response bundle between the effect stages and the shared MAC arbiter.
interface mac_arbiter_if
   import mac_pkg::*;
#(
   parameter int NUM_REQ    = MAC_DEFAULT_NUM_REQ,
   parameter int DATA_WIDTH = MAC_DEFAULT_WIDTH
);
   localparam int ID_WIDTH = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
   logic                          resp_valid;
   logic [ID_WIDTH-1:0]           resp_id;
   logic [DATA_WIDTH-1:0]         resp_data;
   logic                          busy;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, resp_valid, resp_id, resp_data, busy
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, resp_valid, resp_id, resp_data, busy
   );
endinterface

// File: rtl/mul_pipe.sv
// Fixed-latency signed Q1.(W-1) multiplier with valid/ID shift register.
// Define CRUSH_MAC_SATURATE_EN to clamp the min*min product to max positive.
module mul_pipe
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = MAC_DEFAULT_WIDTH,
   parameter int LATENCY    = MAC_DEFAULT_LATENCY,
   parameter int ID_WIDTH   = 2
) (
   input  logic                         clk,
   input  logic                         srst,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   input  logic [ID_WIDTH-1:0]          in_id,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        product,
   output logic [ID_WIDTH-1:0]          out_id,
   output logic                         busy
);
   logic signed [2*DATA_WIDTH-1:0] full_prod;
   logic [DATA_WIDTH-1:0]          prod_next;
   logic                           unused_prod_bits;

   logic [LATENCY-1:0]    valid_reg;
   logic [ID_WIDTH-1:0]   id_reg   [LATENCY];
   logic [DATA_WIDTH-1:0] data_reg [LATENCY];

   // Keeping bits [2W-2:W-1] is an arithmetic shift by W-1 with floor truncation.
   always_comb begin
      full_prod = a * b;
      prod_next = full_prod[2*DATA_WIDTH-2:DATA_WIDTH-1];
`ifdef CRUSH_MAC_SATURATE_EN
      if (a == {1'b1, {(DATA_WIDTH-1){1'b0}}} && b == {1'b1, {(DATA_WIDTH-1){1'b0}}})
         prod_next = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif
   end

   assign unused_prod_bits = ^{full_prod[2*DATA_WIDTH-1], full_prod[DATA_WIDTH-2:0]};

   // Payload only advances alongside a valid bit, so the last result holds between pulses.
   always_ff @(posedge clk) begin
      if (srst) begin
         valid_reg <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            id_reg[k]   <= '0;
            data_reg[k] <= '0;
         end
      end else begin
         valid_reg[0] <= in_valid;
         if (in_valid) begin
            id_reg[0]   <= in_id;
            data_reg[0] <= prod_next;
         end
         for (int k = 1; k < LATENCY; k++) begin
            valid_reg[k] <= valid_reg[k-1];
            if (valid_reg[k-1]) begin
               id_reg[k]   <= id_reg[k-1];
               data_reg[k] <= data_reg[k-1];
            end
         end
      end
   end

   assign out_valid = valid_reg[LATENCY-1];
   assign out_id    = id_reg[LATENCY-1];
   assign product   = data_reg[LATENCY-1];
   assign busy      = |valid_reg;
endmodule

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NUM_REQ requesters.
// Optional min*min saturation is enabled by defining CRUSH_MAC_SATURATE_EN.
module mac_arbiter
   import mac_pkg::*;
#(
   parameter int NUM_REQ    = MAC_DEFAULT_NUM_REQ,
   parameter int DATA_WIDTH = MAC_DEFAULT_WIDTH,
   parameter int LATENCY    = MAC_DEFAULT_LATENCY
) (
   input  logic          clk,
   input  logic          reset,
   mac_arbiter_if.slave  bus
);
   localparam int ID_WIDTH = $clog2(NUM_REQ);

   logic [ID_WIDTH-1:0]    last_grant_reg;
   logic [ID_WIDTH-1:0]    last_grant_next;
   logic [ID_WIDTH-1:0]    grant_id;
   logic                   grant_any;
   logic [MAC_MAX_REQ-1:0] valid_ext;
   int                     pick;
   logic                   unused_pick_bits;
   logic [DATA_WIDTH-1:0]  a_arr [NUM_REQ];
   logic [DATA_WIDTH-1:0]  b_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign a_arr[gi] = bus.req_a[gi*DATA_WIDTH +: DATA_WIDTH];
         assign b_arr[gi] = bus.req_b[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   always_comb begin
      valid_ext                = '0;
      valid_ext[NUM_REQ-1:0]   = bus.req_valid;
      pick                     = rr_pick(valid_ext, int'(last_grant_reg), NUM_REQ);
      grant_any                = (pick >= 0) && !reset;
      grant_id                 = grant_any ? pick[ID_WIDTH-1:0] : '0;
      bus.req_ready            = '0;
      if (grant_any) bus.req_ready[grant_id] = 1'b1;
      last_grant_next          = grant_any ? grant_id : last_grant_reg;
   end

   assign unused_pick_bits = ^pick[31:ID_WIDTH];

   // Pointer at NUM_REQ-1 makes requester 0 the first candidate out of reset.
   always_ff @(posedge clk) begin
      if (reset) last_grant_reg <= ID_WIDTH'(NUM_REQ - 1);
      else       last_grant_reg <= last_grant_next;
   end

   mul_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .LATENCY    (LATENCY),
      .ID_WIDTH   (ID_WIDTH)
   ) u_mul_pipe (
      .clk       (clk),
      .srst      (reset),
      .in_valid  (grant_any),
      .a         (a_arr[grant_id]),
      .b         (b_arr[grant_id]),
      .in_id     (grant_id),
      .out_valid (bus.resp_valid),
      .product   (bus.resp_data),
      .out_id    (bus.resp_id),
      .busy      (bus.busy)
   );
endmodule

// File: tb/tb_mac_arbiter.sv
// Directed-vector bench for mac_arbiter: arithmetic, latency, rotation, back-to-back and mid-run reset.
module tb_mac_arbiter;
   import mac_pkg::*;

   localparam int N = 4;
   localparam int W = 16;
   localparam int L = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   vec_count = 0;
   int   err_count = 0;
   logic [15:0] exp_ovf;

   mac_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();

   mac_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .LATENCY(L)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         err_count++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int idx, input logic [15:0] a, input logic [15:0] b);
      bus.req_a[idx*W +: W] = a;
      bus.req_b[idx*W +: W] = b;
   endtask

   task automatic single_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp, input string tag);
      set_op(idx, a, b);
      bus.req_valid = 4'(1 << idx);
      #1;
      check({tag, " ready"}, 32'(bus.req_ready), 32'(1 << idx));
      check({tag, " busy_t0"}, 32'(bus.busy), 32'd0);
      step();
      bus.req_valid = '0;
      check({tag, " busy_t1"}, 32'(bus.busy), 32'd1);
      for (int c = 1; c < L; c++) begin
         check($sformatf("%s early_valid t%0d", tag, c), 32'(bus.resp_valid), 32'd0);
         step();
      end
      check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, " resp_id"}, 32'(bus.resp_id), 32'(idx));
      check({tag, " resp_data"}, 32'(bus.resp_data), 32'(exp));
      step();
      check({tag, " pulse_end"}, 32'(bus.resp_valid), 32'd0);
      check({tag, " data_hold"}, 32'(bus.resp_data), 32'(exp));
      check({tag, " busy_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
`ifdef CRUSH_MAC_SATURATE_EN
      exp_ovf = 16'h7FFF;
`else
      exp_ovf = 16'h8000;
`endif
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;

      // Reset state and ready suppression while reset is high.
      reset = 1'b1;
      step();
      step();
      bus.req_valid = 4'hF;
      #1;
      check("ready_in_reset", 32'(bus.req_ready), 32'd0);
      bus.req_valid = '0;
      check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst resp_id", 32'(bus.resp_id), 32'd0);
      check("rst resp_data", 32'(bus.resp_data), 32'd0);
      check("rst busy", 32'(bus.busy), 32'd0);
      reset = 1'b0;
      step();

      // Arithmetic vectors, one requester at a time.
      single_op(0, 16'h4000, 16'h4000, 16'h2000, "half_sq");
      single_op(1, 16'hC000, 16'h4000, 16'hE000, "neg_quarter");
      single_op(2, 16'h0001, 16'hFFFF, 16'hFFFF, "floor_trunc");
      single_op(3, 16'h8000, 16'h8000, exp_ovf,  "min_min");
      single_op(0, 16'h7FFF, 16'h7FFF, 16'h7FFE, "max_max");
      single_op(1, 16'h8000, 16'h7FFF, 16'h8001, "min_max");

      // All requesters valid for 8 cycles right after reset.
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < N; i++) set_op(i, 16'((i + 1) << 8), 16'h4000);
      for (int c = 0; c < 12; c++) begin
         bus.req_valid = (c < 8) ? 4'hF : 4'h0;
         #1;
         if (c < 8) check($sformatf("rr ready c%0d", c), 32'(bus.req_ready), 32'(1 << (c % 4)));
         if (c >= 1 && c <= 10) check($sformatf("rr busy c%0d", c), 32'(bus.busy), 32'd1);
         if (c >= 3 && c <= 10) begin
            check($sformatf("rr resp_valid c%0d", c), 32'(bus.resp_valid), 32'd1);
            check($sformatf("rr resp_id c%0d", c), 32'(bus.resp_id), 32'((c - 3) % 4));
            check($sformatf("rr resp_data c%0d", c), 32'(bus.resp_data), 32'(((c - 3) % 4 + 1) << 7));
         end
         if (c == 11) begin
            check("rr drained valid", 32'(bus.resp_valid), 32'd0);
            check("rr drained busy", 32'(bus.busy), 32'd0);
         end
         step();
      end

      // req2 issues five back-to-back transfers, then req1 joins and wins.
      for (int c = 0; c < 10; c++) begin
         if (c < 5) begin
            set_op(2, 16'(16'h1000 * (c + 1)), 16'h4000);
            bus.req_valid = 4'b0100;
         end else if (c == 5) begin
            set_op(1, 16'h2000, 16'h2000);
            bus.req_valid = 4'b0110;
         end else begin
            bus.req_valid = 4'b0000;
         end
         #1;
         if (c < 5)  check($sformatf("b2b ready c%0d", c), 32'(bus.req_ready), 32'b0100);
         if (c == 5) check("b2b ready req1", 32'(bus.req_ready), 32'b0010);
         if (c >= 3 && c <= 8) begin
            check($sformatf("b2b resp_valid c%0d", c), 32'(bus.resp_valid), 32'd1);
            check($sformatf("b2b resp_id c%0d", c), 32'(bus.resp_id), (c < 8) ? 32'd2 : 32'd1);
            check($sformatf("b2b resp_data c%0d", c), 32'(bus.resp_data),
                  (c < 8) ? 32'(16'h0800 * (c - 2)) : 32'h0800);
         end
         if (c == 9) check("b2b drained", 32'(bus.resp_valid), 32'd0);
         step();
      end

      // Three transfers in flight, one-cycle reset, then req1/req3 re-arbitrated.
      set_op(0, 16'h4000, 16'h4000);
      set_op(1, 16'h4000, 16'h2000);
      set_op(3, 16'h6000, 16'h4000);
      for (int c = 0; c < 10; c++) begin
         case (c)
            0, 1, 2: bus.req_valid = 4'b0001;
            3:       begin bus.req_valid = 4'b1010; reset = 1'b1; end
            4:       begin bus.req_valid = 4'b1010; reset = 1'b0; end
            5:       bus.req_valid = 4'b1000;
            default: bus.req_valid = 4'b0000;
         endcase
         #1;
         if (c <= 2) check($sformatf("mid ready c%0d", c), 32'(bus.req_ready), 32'b0001);
         if (c == 3) check("mid ready in reset", 32'(bus.req_ready), 32'd0);
         if (c == 4) begin
            check("mid busy after rst", 32'(bus.busy), 32'd0);
            check("mid ready req1 first", 32'(bus.req_ready), 32'b0010);
         end
         if (c == 5) check("mid ready req3", 32'(bus.req_ready), 32'b1000);
         if (c >= 4 && c <= 6) check($sformatf("mid discarded c%0d", c), 32'(bus.resp_valid), 32'd0);
         if (c == 7 || c == 8) begin
            check($sformatf("mid resp_valid c%0d", c), 32'(bus.resp_valid), 32'd1);
            check($sformatf("mid resp_id c%0d", c), 32'(bus.resp_id), (c == 7) ? 32'd1 : 32'd3);
            check($sformatf("mid resp_data c%0d", c), 32'(bus.resp_data), (c == 7) ? 32'h1000 : 32'h3000);
         end
         if (c == 9) begin
            check("mid end valid", 32'(bus.resp_valid), 32'd0);
            check("mid end busy", 32'(bus.busy), 32'd0);
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end
endmodule
